seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock under a start/done handshake.
// The dividend register doubles as the quotient shift register while CALC runs.
module seq_divider #(
  parameter int DIVISOR_W  = 8,
  parameter int DIVIDEND_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  logic [DIVIDEND_W-1:0]   dvd_work;
  logic [DIVISOR_W-1:0]    dvs_work;
  logic [DIVISOR_W-1:0]    rem_work;
  logic [CNT_W-1:0]        cnt;

  logic [DIVISOR_W:0]      shifted;
  logic                    fits;
  logic [DIVISOR_W-1:0]    diff;
  logic [DIVISOR_W-1:0]    rem_next;
  logic [DIVIDEND_W-1:0]   q_next;
  logic                    last;

  // The stored remainder is always below the divisor, so the shifted partial
  // remainder needs one extra bit and the difference always fits in DIVISOR_W.
  always_comb begin
    shifted  = {rem_work, dvd_work[DIVIDEND_W-1]};
    fits     = (shifted >= {1'b0, dvs_work});
    diff     = shifted[DIVISOR_W-1:0] - dvs_work;
    rem_next = fits ? diff : shifted[DIVISOR_W-1:0];
    q_next   = {dvd_work[DIVIDEND_W-2:0], fits};
    last     = (cnt == CNT_W'(DIVIDEND_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_work    <= '0;
      dvs_work    <= '0;
      rem_work    <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvd_work    <= dividend;
            dvs_work    <= divisor;
            rem_work    <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            state       <= CALC;
            ready       <= 1'b0;
            busy        <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          // A zero divisor resolves in a single cycle so done lands one edge after acceptance.
          if (dvs_work == '0) begin
            quotient    <= '1;
            remainder   <= dvd_work[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
            state       <= DONE;
            done        <= 1'b1;
            ready       <= 1'b1;
            busy        <= 1'b0;
          end else begin
            rem_work <= rem_next;
            dvd_work <= q_next;
            cnt      <= cnt + CNT_W'(1);
            if (last) begin
              quotient  <= q_next;
              remainder <= rem_next;
              state     <= DONE;
              done      <= 1'b1;
              ready     <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus scoreboard, then abort and back-to-back corners.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready, busy, done, div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  seq_divider #(.DIVISOR_W(8), .DIVIDEND_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Waits for done after an accepting edge; optionally injects a start mid-CALC,
  // checks that the quotient holds at cycle 8, or re-launches 9/9 in the done cycle.
  task automatic wait_done(input int exp_lat, input int inject_at, input bit b2b, input int hold_q);
    int   lat    = -1;
    int   busy_n = 0;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == inject_at) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 8'd9;
      end else if (inject_at >= 0 && i == inject_at + 1) begin
        start = 1'b0;
      end
      if (hold_q >= 0 && i == 8) check("hold_quotient", {16'h0, quotient}, hold_q);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_n++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    if (exp_lat > 1) check("busy_cycles", busy_n, exp_lat);
    if (lat >= 0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got done with no expected result");
      end else begin
        e = sb.pop_front();
        check("quotient", {16'h0, quotient}, {16'h0, e.q});
        check("remainder", {24'h0, remainder}, {24'h0, e.r});
        check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dz});
        check("ready_at_done", {31'h0, ready}, 1);
      end
    end
    if (b2b) begin
      start    = 1'b1;
      dividend = 16'd9;
      divisor  = 8'd9;
      sb.push_back('{q: 16'd1, r: 8'd0, dz: 1'b0});
      @(posedge clk);
      #1;
      start = 1'b0;
    end else begin
      @(negedge clk);
      check("done_single_pulse", {31'h0, done}, 0);
    end
  endtask

  initial begin
    int seen_done;
    vecs[0] = '{a: 16'd200,   b: 8'd7,   q: 16'd28,    r: 8'd4,   dz: 1'b0};
    vecs[1] = '{a: 16'd65535, b: 8'd255, q: 16'd257,   r: 8'd0,   dz: 1'b0};
    vecs[2] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,   dz: 1'b0};
    vecs[3] = '{a: 16'd5,     b: 8'd9,   q: 16'd0,     r: 8'd5,   dz: 1'b0};
    vecs[4] = '{a: 16'd0,     b: 8'd3,   q: 16'd0,     r: 8'd0,   dz: 1'b0};
    vecs[5] = '{a: 16'd100,   b: 8'd0,   q: 16'hFFFF,  r: 8'h64,  dz: 1'b1};
    vecs[6] = '{a: 16'd10,    b: 8'd3,   q: 16'd3,     r: 8'd1,   dz: 1'b0};
    vecs[7] = '{a: 16'd12345, b: 8'd123, q: 16'd100,   r: 8'd45,  dz: 1'b0};
    vecs[8] = '{a: 16'h1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'h34,  dz: 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_ready", {31'h0, ready}, 1);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_quotient", {16'h0, quotient}, 0);
    check("rst_remainder", {24'h0, remainder}, 0);
    check("rst_div_by_zero", {31'h0, div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      sb.push_back('{q: vecs[k].q, r: vecs[k].r, dz: vecs[k].dz});
      launch(vecs[k].a, vecs[k].b);
      wait_done((vecs[k].b == 8'd0) ? 1 : 16, -1, 1'b0, -1);
    end

    // Start while busy is ignored, then start held in the done cycle is taken back-to-back.
    sb.push_back('{q: 16'd100, r: 8'd0, dz: 1'b0});
    launch(16'd1000, 8'd10);
    wait_done(16, 4, 1'b1, -1);
    wait_done(16, -1, 1'b0, 100);

    // Reset mid-CALC aborts without a done pulse.
    launch(16'd300, 8'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", {31'h0, ready}, 1);
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_done", {31'h0, done}, 0);
    check("abort_quotient", {16'h0, quotient}, 0);
    check("abort_remainder", {24'h0, remainder}, 0);
    check("abort_div_by_zero", {31'h0, div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("no_done_after_abort", seen_done, 0);
    sb.push_back('{q: 16'd42, r: 8'd6, dz: 1'b0});
    launch(16'd300, 8'd7);
    wait_done(16, -1, 1'b0, -1);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
